// File: rtl/interrupt_claim_complete_arbiter.sv
// Claim/complete side of the interrupt controller: scans pending sources one per cycle,
// notifies the core of the strongest candidate, and manages the claim/complete handshake.
module interrupt_claim_complete_arbiter #(
    parameter int N_interrupts = 32
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [N_interrupts-1:0]       pending_interrupts,
    input  logic [N_interrupts-1:0][31:0] interrupt_priority_regs,
    input  logic [2:0]                    priority_threshold,
    input  logic                          claim_ren,
    input  logic                          complete_wen,
    input  logic [31:0]                   complete_wdata,
    output logic [31:0]                   claim_id,
    output logic                          interrupt_req,
    output logic [N_interrupts-1:0]       active_interrupt,
    output logic                          interrupt_claimed
);

    localparam int IDX_W = (N_interrupts > 1) ? $clog2(N_interrupts) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_interrupts - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        NOTIFY,
        CLAIM,
        SERVICE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [31:0]             best_id_q, best_id_d;
    logic [2:0]              best_prio_q, best_prio_d;
    logic [31:0]             claim_id_q, claim_id_d;
    logic                    req_q, req_d;
    logic                    claimed_q, claimed_d;
    logic [N_interrupts-1:0] active_q, active_d;

    logic [N_interrupts-1:0][2:0]  prio3;
    logic [N_interrupts-1:0][28:0] prio_hi;
    logic [N_interrupts-1:0]       best_onehot;
    logic                          unused_prio_hi;

    // Only the low three priority bits take part in arbitration.
    generate
        for (genvar gi = 0; gi < N_interrupts; gi++) begin : g_src
            assign prio3[gi]       = interrupt_priority_regs[gi][2:0];
            assign prio_hi[gi]     = interrupt_priority_regs[gi][31:3];
            assign best_onehot[gi] = (best_id_q == 32'(gi + 1));
        end
    endgenerate
    assign unused_prio_hi = ^prio_hi;

    logic        cur_wins;
    logic [2:0]  cur_prio;
    logic [31:0] cur_id;

    assign cur_prio = prio3[idx_q];
    assign cur_id   = 32'(idx_q) + 32'd1;
    // Strict compare against the running best keeps the lower ID on ties.
    assign cur_wins = pending_interrupts[idx_q]
                   && (cur_prio > priority_threshold)
                   && (cur_prio > best_prio_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        best_id_d   = best_id_q;
        best_prio_d = best_prio_q;
        claim_id_d  = claim_id_q;
        req_d       = req_q;
        claimed_d   = 1'b0;
        active_d    = '0;
        case (state_q)
            IDLE: begin
                if (|pending_interrupts) begin
                    state_d     = SCAN;
                    idx_d       = '0;
                    best_id_d   = '0;
                    best_prio_d = '0;
                end
            end
            SCAN: begin
                if (cur_wins) begin
                    best_id_d   = cur_id;
                    best_prio_d = cur_prio;
                end
                if (idx_q == LAST_IDX) begin
                    if (best_id_d != 32'd0) begin
                        state_d    = NOTIFY;
                        req_d      = 1'b1;
                        claim_id_d = best_id_d;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            NOTIFY: begin
                // A claim in the same cycle as a threshold raise still wins.
                if (claim_ren) begin
                    state_d   = CLAIM;
                    req_d     = 1'b0;
                    claimed_d = 1'b1;
                    active_d  = best_onehot;
                end else if (priority_threshold >= best_prio_q) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    claim_id_d = '0;
                end
            end
            CLAIM: begin
                state_d = SERVICE;
            end
            SERVICE: begin
                if (complete_wen && (complete_wdata == claim_id_q)) begin
                    state_d    = IDLE;
                    claim_id_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            best_id_q   <= '0;
            best_prio_q <= '0;
            claim_id_q  <= '0;
            req_q       <= 1'b0;
            claimed_q   <= 1'b0;
            active_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            claim_id_q  <= claim_id_d;
            req_q       <= req_d;
            claimed_q   <= claimed_d;
            active_q    <= active_d;
        end
    end

    // The claim register reads 0 during the claim pulse cycle and outside notify/service.
    assign claim_id          = (state_q == CLAIM) ? 32'd0 : claim_id_q;
    assign interrupt_req     = req_q;
    assign active_interrupt  = active_q;
    assign interrupt_claimed = claimed_q;

endmodule

// File: tb/tb_interrupt_claim_complete_arbiter.sv
// Directed bench: a 32-source arbiter for the main scenarios and a 33-source one for
// the non-power-of-two scan length.
module tb_interrupt_claim_complete_arbiter;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    // Instance A: 32 sources
    logic [31:0]       pend_a;
    logic [31:0][31:0] prio_a;
    logic [2:0]        thr_a;
    logic              claim_ren_a, complete_wen_a;
    logic [31:0]       wdata_a;
    logic [31:0]       claim_id_a;
    logic              req_a, claimed_a;
    logic [31:0]       active_a;

    // Instance B: 33 sources
    logic [32:0]       pend_b;
    logic [32:0][31:0] prio_b;
    logic [2:0]        thr_b;
    logic              claim_ren_b, complete_wen_b;
    logic [31:0]       wdata_b;
    logic [31:0]       claim_id_b;
    logic              req_b, claimed_b;
    logic [32:0]       active_b;

    interrupt_claim_complete_arbiter #(.N_interrupts(32)) dut_a (
        .clk                     (clk),
        .n_rst                   (n_rst),
        .pending_interrupts      (pend_a),
        .interrupt_priority_regs (prio_a),
        .priority_threshold      (thr_a),
        .claim_ren               (claim_ren_a),
        .complete_wen            (complete_wen_a),
        .complete_wdata          (wdata_a),
        .claim_id                (claim_id_a),
        .interrupt_req           (req_a),
        .active_interrupt        (active_a),
        .interrupt_claimed       (claimed_a)
    );

    interrupt_claim_complete_arbiter #(.N_interrupts(33)) dut_b (
        .clk                     (clk),
        .n_rst                   (n_rst),
        .pending_interrupts      (pend_b),
        .interrupt_priority_regs (prio_b),
        .priority_threshold      (thr_b),
        .claim_ren               (claim_ren_b),
        .complete_wen            (complete_wen_b),
        .complete_wdata          (wdata_b),
        .claim_id                (claim_id_b),
        .interrupt_req           (req_b),
        .active_interrupt        (active_b),
        .interrupt_claimed       (claimed_b)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        $display("check %-24s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic claim_a();
        claim_ren_a = 1'b1;
        step(1);
        claim_ren_a = 1'b0;
    endtask

    task automatic complete_a(input logic [31:0] id);
        complete_wen_a = 1'b1;
        wdata_a        = id;
        step(1);
        complete_wen_a = 1'b0;
        wdata_a        = '0;
    endtask

    initial begin
        n_rst = 1'b0;
        pend_a = '0; prio_a = '0; thr_a = 3'd0;
        claim_ren_a = 1'b0; complete_wen_a = 1'b0; wdata_a = '0;
        pend_b = '0; prio_b = '0; thr_b = 3'd0;
        claim_ren_b = 1'b0; complete_wen_b = 1'b0; wdata_b = '0;
        step(3);
        chk("rst_claim_id", 64'(claim_id_a), 64'd0);
        chk("rst_req", 64'(req_a), 64'd0);
        chk("rst_active", 64'(active_a), 64'd0);
        chk("rst_claimed", 64'(claimed_a), 64'd0);
        chk("rst_b_req", 64'(req_b), 64'd0);
        n_rst = 1'b1;
        step(2);

        // Single source 5, prio 3: request after exactly 33 cycles
        pend_a[5] = 1'b1; prio_a[5] = 32'd3;
        step(32);
        chk("t1_req_early", 64'(req_a), 64'd0);
        step(1);
        chk("t1_req", 64'(req_a), 64'd1);
        chk("t1_claim_id", 64'(claim_id_a), 64'd6);
        claim_ren_a = 1'b1;
        chk("t1_read_id", 64'(claim_id_a), 64'd6);
        step(1);
        claim_ren_a = 1'b0;
        chk("t1_claimed", 64'(claimed_a), 64'd1);
        chk("t1_active", 64'(active_a), 64'h20);
        chk("t1_req_drop", 64'(req_a), 64'd0);
        pend_a[5] = 1'b0;
        step(1);
        chk("t1_pulse_end", 64'(claimed_a), 64'd0);
        chk("t1_service_id", 64'(claim_id_a), 64'd6);
        complete_a(32'd6);
        chk("t1_done_id", 64'(claim_id_a), 64'd0);
        step(2);

        // Tie between sources 3 and 9 at prio 4 goes to ID 4
        pend_a[3] = 1'b1; pend_a[9] = 1'b1;
        prio_a[3] = 32'd4; prio_a[9] = 32'd4;
        step(33);
        chk("t2_req", 64'(req_a), 64'd1);
        chk("t2_tie_id", 64'(claim_id_a), 64'd4);
        claim_a();
        chk("t2_active", 64'(active_a), 64'h8);
        pend_a[3] = 1'b0;
        step(1);
        prio_a[9] = 32'd5; pend_a[3] = 1'b1;
        claim_ren_a = 1'b1;
        chk("t2_service_read", 64'(claim_id_a), 64'd4);
        step(1);
        claim_ren_a = 1'b0;
        chk("t2_no_pulse", 64'(claimed_a), 64'd0);
        complete_a(32'd4);
        step(33);
        chk("t2_rerun_req", 64'(req_a), 64'd1);
        chk("t2_rerun_id", 64'(claim_id_a), 64'd10);
        claim_a();
        chk("t2_rerun_active", 64'(active_a), 64'h200);
        pend_a = '0;
        step(1);
        complete_a(32'd10);

        // Threshold raised while notifying drops the request
        pend_a[1] = 1'b1; prio_a[1] = 32'd2;
        step(33);
        chk("t2b_req", 64'(req_a), 64'd1);
        chk("t2b_id", 64'(claim_id_a), 64'd2);
        pend_a[1] = 1'b0; thr_a = 3'd2;
        step(1);
        chk("t2b_req_drop", 64'(req_a), 64'd0);
        chk("t2b_id_drop", 64'(claim_id_a), 64'd0);
        step(3);

        // Priority equal to threshold never wins
        pend_a[7] = 1'b1; prio_a[7] = 32'd2;
        step(33);
        chk("t3_no_req", 64'(req_a), 64'd0);
        step(40);
        chk("t3_no_req_later", 64'(req_a), 64'd0);
        chk("t3_id_zero", 64'(claim_id_a), 64'd0);
        pend_a = '0; thr_a = 3'd0;
        step(40);

        // ID 1 claim, mismatched complete ignored
        pend_a[0] = 1'b1; prio_a[0] = 32'd1;
        step(33);
        chk("t4_id", 64'(claim_id_a), 64'd1);
        claim_a();
        chk("t4_claimed", 64'(claimed_a), 64'd1);
        chk("t4_active", 64'(active_a), 64'h1);
        pend_a[0] = 1'b0;
        step(1);
        complete_a(32'd2);
        chk("t4_bad_complete", 64'(claim_id_a), 64'd1);
        complete_a(32'd1);
        chk("t4_good_complete", 64'(claim_id_a), 64'd0);
        step(2);

        // Reset mid-scan abandons the scan; a full scan follows release
        pend_a[5] = 1'b1; prio_a[5] = 32'd3;
        step(10);
        n_rst = 1'b0;
        #2;
        chk("t5_scan_rst_req", 64'(req_a), 64'd0);
        n_rst = 1'b1;
        step(32);
        chk("t5_fresh_early", 64'(req_a), 64'd0);
        step(1);
        chk("t5_fresh_req", 64'(req_a), 64'd1);
        claim_a();
        step(1);
        chk("t5_service_id", 64'(claim_id_a), 64'd6);
        n_rst = 1'b0;
        #2;
        chk("t5_svc_rst_id", 64'(claim_id_a), 64'd0);
        chk("t5_svc_rst_claimed", 64'(claimed_a), 64'd0);
        chk("t5_svc_rst_active", 64'(active_a), 64'd0);
        n_rst = 1'b1;
        step(1);
        chk("t5_no_pulse", 64'(claimed_a), 64'd0);
        step(32);
        chk("t5_rescan_req", 64'(req_a), 64'd1);
        chk("t5_rescan_id", 64'(claim_id_a), 64'd6);

        // 33 sources: only the last one pending, 34-cycle latency
        pend_b[32] = 1'b1; prio_b[32] = 32'd1;
        step(33);
        chk("t6_req_early", 64'(req_b), 64'd0);
        step(1);
        chk("t6_req", 64'(req_b), 64'd1);
        chk("t6_id", 64'(claim_id_b), 64'd33);
        claim_ren_b = 1'b1;
        step(1);
        claim_ren_b = 1'b0;
        chk("t6_claimed", 64'(claimed_b), 64'd1);
        chk("t6_active", 64'(active_b), 64'h1_0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/interrupt_claim_complete_arbiter.md
Name: interrupt_claim_complete_arbiter

Overview:
- Consumer side of the PLIC pending/priority register block.
- Sequentially scans the pending vector and the per-source priorities, selects the winning source, and raises a request to the core.
- Serves the core's claim read and complete write.
- On claim, drives the one-hot active vector and a claim pulse back to the pending logic, which clears that pending bit.

Parameters:
- N_interrupts, 32, number of interrupt sources. Source index i has ID i+1; ID 0 means "no interrupt".

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset, asynchronous, active-low
- pending_interrupts  input  N_interrupts  pending bit per source, from the pending/priority block
- interrupt_priority_regs  input  N_interrupts x 32  per-source priority; only bits [2:0] are significant
- priority_threshold  input  3  a source wins only if its priority is strictly greater than this
- claim_ren  input  1  core reads the claim register this cycle
- complete_wen  input  1  core writes the complete register this cycle
- complete_wdata  input  32  ID being completed
- claim_id  output  32  ID of the current candidate (0 if none)
- interrupt_req  output  1  interrupt request to the core
- active_interrupt  output  N_interrupts  one-hot of the claimed source; valid only while interrupt_claimed=1
- interrupt_claimed  output  1  one-cycle claim pulse to the pending logic

Behaviour:
- Reset (asynchronous, n_rst=0):
  - state=IDLE; scan index, best_id and best_prio cleared.
  - claim_id=0, interrupt_req=0, active_interrupt=0, interrupt_claimed=0.
  - Reset mid-scan or mid-service abandons everything. No claim pulse is produced.
- FSM states: IDLE, SCAN, NOTIFY, CLAIM, SERVICE.
- IDLE:
  - If any pending bit is set, go to SCAN next cycle with index=0, best_id=0, best_prio=0.
  - Otherwise stay in IDLE.
- SCAN:
  - Examines one source per cycle, index 0..N_interrupts-1.
  - Source i becomes the candidate if pending[i]=1, prio[i][2:0] > priority_threshold, and prio[i][2:0] > best_prio.
  - Strict greater-than means ties keep the lower ID. Priority 0 never wins.
  - After index N_interrupts-1 is examined (N_interrupts cycles total):
    - best_id != 0: go to NOTIFY.
    - best_id = 0: go to IDLE.
  - The index counter must be wide enough for N_interrupts that are not a power of two. No wrap inside a scan.
- NOTIFY:
  - interrupt_req=1 (registered) and claim_id=best_id.
  - The candidate is frozen: no re-scan and no preemption while in NOTIFY.
  - claim_ren=1: go to CLAIM.
  - If priority_threshold rises to >= best_prio without a claim: go to IDLE and drop interrupt_req. If claim_ren coincides with this, the claim wins.
- CLAIM (exactly one cycle):
  - interrupt_claimed=1.
  - active_interrupt has bit best_id-1 set.
  - interrupt_req=0.
  - Then go to SERVICE.
- SERVICE:
  - claim_id keeps the serviced ID; interrupt_req=0.
  - complete_wen=1 with complete_wdata==claim_id: go to IDLE next cycle and clear claim_id.
  - A complete with a mismatched ID is ignored (stay in SERVICE).
  - Only one source is in service at a time.
- claim_id read semantics:
  - Core sees claim_id combinationally in the claim_ren cycle.
  - claim_ren outside NOTIFY has no effect and returns 0, except in SERVICE, where it returns the serviced ID with no pulse.
- complete_wen outside SERVICE is ignored.
- Latency:
  - Pending asserted to interrupt_req = N_interrupts+1 cycles (1 cycle IDLE->SCAN, then N_interrupts scan cycles).
  - claim_ren to interrupt_claimed = 1 cycle.
  - Matching complete to the next SCAN start = 2 cycles if pending is still nonzero.
- All outputs are registered except the combinational claim_id read path.

Test Plan:
- N=32, threshold=0. Pending bit 5 set, prio[5]=3 -> interrupt_req rises 33 cycles later; claim_id=6.
- Pending 3 and 9 set, both prio=4 -> claim_id=4 (tie goes to the lower ID). Then prio[9]=5, re-run after complete -> claim_id=10.
- Pending 7 set, prio[7]=2, threshold=2 -> no interrupt_req; the FSM returns to IDLE after the scan and keeps rescanning.
- Claim source 0 (ID 1) -> one-cycle interrupt_claimed with active_interrupt=32'h1. Then complete_wdata=2 is ignored (stays in SERVICE), complete_wdata=1 returns to IDLE.
- Assert n_rst low mid-SCAN and separately during SERVICE -> all outputs 0 immediately, no interrupt_claimed pulse, a fresh scan starts after release.
- N=33, only source 32 pending, prio=1 -> claim_id=33 after a 34-cycle latency; active_interrupt bit 32 set on claim.
